// File: rtl/led_frame_buffer.sv
// led_frame_buffer: double-buffered pixel collector that assembles LEDS pixels and hands a frame to LEDDriver.
// Optional write-port brightness scaling is enabled by defining LED_FRAME_BRIGHTNESS_EN.
module led_frame_buffer #(
  parameter int unsigned LEDS = 50
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  input  logic [23:0]          pix_rgb,
  input  logic                 pix_last,
  input  logic [7:0]           brightness,
  output logic [24*LEDS-1:0]   led_rgb,
  output logic                 start,
  input  logic                 done,
  output logic                 frame_err
);

  localparam int unsigned PIX_W = 24;
  localparam int unsigned IDX_W = $clog2(LEDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(LEDS - 1);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [LEDS-1:0][PIX_W-1:0] wbuf_q, wbuf_d;
  logic [LEDS-1:0][PIX_W-1:0] disp_q, disp_d;
  logic [IDX_W-1:0]           wr_idx_q, wr_idx_d;
  logic                       busy_q, busy_d;
  logic                       ready_q, ready_d;
  logic                       start_q, start_d;
  logic                       err_q, err_d;
  logic                       accept;
  logic [PIX_W-1:0]           pix_store;

`ifdef LED_FRAME_BRIGHTNESS_EN
  // 8x9 multiply by (brightness+1) keeps 255 as identity and 0 as black
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'(c) * 16'({1'b0, b} + 9'd1);
    return 8'(prod >> 8);
  endfunction

  assign pix_store = {scale_ch(pix_rgb[23:16], brightness),
                      scale_ch(pix_rgb[15:8],  brightness),
                      scale_ch(pix_rgb[7:0],   brightness)};
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pix_store         = pix_rgb;
`endif

  // ready is forced low for the whole reset assertion, not just after the edge
  assign pix_ready = ready_q & ~rst;
  assign accept    = pix_valid & pix_ready;
  assign led_rgb   = disp_q;
  assign start     = start_q;
  assign frame_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_FILL;
      wbuf_q   <= '0;
      disp_q   <= '0;
      wr_idx_q <= '0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b1;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wbuf_q   <= wbuf_d;
      disp_q   <= disp_d;
      wr_idx_q <= wr_idx_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wbuf_d   = wbuf_q;
    disp_d   = disp_q;
    wr_idx_d = wr_idx_q;
    busy_d   = busy_q;
    ready_d  = ready_q;
    start_d  = 1'b0;
    err_d    = 1'b0;

    if (busy_q && done) begin
      busy_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (accept) begin
          wbuf_d[wr_idx_q] = pix_store;
          if (wr_idx_q == IDX_LAST || pix_last) begin
            state_d  = ST_FULL;
            wr_idx_d = '0;
            ready_d  = 1'b0;
            err_d    = pix_last && (wr_idx_q != IDX_LAST);
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      end
      ST_FULL: begin
        // commit waits on the registered busy, so done costs one extra cycle
        if (!busy_q) begin
          disp_d  = wbuf_q;
          start_d = 1'b1;
          busy_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_FILL;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_led_frame_buffer.sv
// tb_led_frame_buffer: directed and randomized frames checked against a frame-level reference model.
module tb_led_frame_buffer;

  localparam int unsigned LEDS = 4;
  localparam int unsigned FW   = 24 * LEDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          pix_valid;
  logic          pix_ready;
  logic [23:0]   pix_rgb;
  logic          pix_last;
  logic [7:0]    brightness;
  logic [FW-1:0] led_rgb;
  logic          start;
  logic          done;
  logic          frame_err;

  always #5 clk = ~clk;

  led_frame_buffer #(.LEDS(LEDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_rgb    (pix_rgb),
    .pix_last   (pix_last),
    .brightness (brightness),
    .led_rgb    (led_rgb),
    .start      (start),
    .done       (done),
    .frame_err  (frame_err)
  );

  // Reference model: write buffer, displayed frame, next slot, expected error flag
  logic [23:0] mw [LEDS];
  logic [23:0] md [LEDS];
  int          midx;
  logic        exp_err;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [23:0] expect_store(input logic [23:0] px);
`ifdef LED_FRAME_BRIGHTNESS_EN
    int k, r, g, b;
    k = int'(brightness) + 1;
    r = (int'(px[23:16]) * k) / 256;
    g = (int'(px[15:8])  * k) / 256;
    b = (int'(px[7:0])   * k) / 256;
    return {8'(r), 8'(g), 8'(b)};
`else
    return px;
`endif
  endfunction

  function automatic logic [FW-1:0] disp_model();
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < LEDS; i++) v[24*i +: 24] = md[i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks = checks + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < LEDS; i++) begin
      mw[i] = '0;
      md[i] = '0;
    end
    midx    = 0;
    exp_err = 1'b0;
  endtask

  // Offer one pixel and wait (bounded) for it to be accepted
  task automatic push(input logic [23:0] px, input logic last);
    int waited;
    waited    = 0;
    pix_valid = 1'b1;
    pix_rgb   = px;
    pix_last  = last;
    while (!pix_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("push_ready", FW'(pix_ready), FW'(1'b1));
    if (pix_ready) begin
      exp_err  = last && (midx != LEDS - 1);
      mw[midx] = expect_store(px);
      midx     = (midx == LEDS - 1 || last) ? 0 : midx + 1;
      tick();
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  // Called just after the frame-ending accept with the driver idle
  task automatic expect_commit(input string tag);
    chk({tag, "_err"},   FW'(frame_err), FW'(exp_err));
    chk({tag, "_rdy0"},  FW'(pix_ready), FW'(1'b0));
    chk({tag, "_nost"},  FW'(start),     FW'(1'b0));
    tick();
    md = mw;
    chk({tag, "_start"}, FW'(start),     FW'(1'b1));
    chk({tag, "_led"},   led_rgb,        disp_model());
    chk({tag, "_err0"},  FW'(frame_err), FW'(1'b0));
    chk({tag, "_rdy1"},  FW'(pix_ready), FW'(1'b1));
    tick();
    chk({tag, "_st0"},   FW'(start),     FW'(1'b0));
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [23:0] px;
    logic [FW-1:0] frame_exp;
    int len;
    logic last;

    rst = 1'b1; pix_valid = 1'b0; pix_rgb = '0; pix_last = 1'b0;
    brightness = 8'd255; done = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_ready", FW'(pix_ready), FW'(1'b0));
    chk("rst_led",   led_rgb,        '0);
    chk("rst_start", FW'(start),     FW'(1'b0));
    chk("rst_err",   FW'(frame_err), FW'(1'b0));
    rst = 1'b0;
    #1;
    chk("post_rst_ready", FW'(pix_ready), FW'(1'b1));

    // Full frame without pix_last, one pixel per cycle
    push(24'h010203, 1'b0);
    push(24'h040506, 1'b0);
    push(24'h070809, 1'b0);
    push(24'h0A0B0C, 1'b0);
    expect_commit("t1");
    frame_exp = 96'h0A0B0C_070809_040506_010203;
    chk("t1_const", led_rgb, frame_exp);

    // Second frame fills while the driver is busy; commit only after done
    brightness = 8'($urandom);
    for (int j = 0; j < LEDS; j++) push(24'($urandom), 1'b0);
    chk("t2_err", FW'(frame_err), FW'(1'b0));
    repeat (3) begin
      chk("t2_hold_rdy", FW'(pix_ready), FW'(1'b0));
      chk("t2_hold_led", led_rgb,        disp_model());
      chk("t2_hold_st",  FW'(start),     FW'(1'b0));
      tick();
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("t2_k_st",  FW'(start), FW'(1'b0));
    chk("t2_k_led", led_rgb,    disp_model());
    tick();
    md = mw;
    chk("t2_k1_st",  FW'(start), FW'(1'b1));
    chk("t2_k1_led", led_rgb,    disp_model());
    tick();
    chk("t2_k2_st",  FW'(start), FW'(1'b0));

    // Short frame: two pixels, upper LEDs keep stale write-buffer data
    pulse_done();
    brightness = 8'($urandom);
    push(24'($urandom), 1'b0);
    push(24'($urandom), 1'b1);
    expect_commit("t3");
    pulse_done();
    pulse_done();

    // Valid toggling 1-0-1-0: accepted pixels land at consecutive slots
    for (int j = 0; j < LEDS; j++) begin
      push(24'($urandom), (j == LEDS - 1));
      if (j != LEDS - 1) tick();
    end
    expect_commit("t4");
    pulse_done();

    // Randomized frames: random length, gaps, brightness and done latency
    for (int f = 0; f < 20; f++) begin
      len = int'($urandom_range(1, LEDS));
      brightness = 8'($urandom);
      for (int j = 0; j < len; j++) begin
        repeat ($urandom_range(0, 2)) tick();
        if (j == len - 1) last = (len < LEDS) ? 1'b1 : 1'($urandom);
        else last = 1'b0;
        push(24'($urandom), last);
      end
      expect_commit("rnd");
      repeat ($urandom_range(0, 3)) tick();
      pulse_done();
    end

    // Reset one cycle after start clears busy and the displayed frame
    for (int j = 0; j < LEDS; j++) push(24'($urandom), 1'b0);
    expect_commit("t5a");
    rst = 1'b1;
    tick();
    model_reset();
    chk("t5_led",   led_rgb,        '0);
    chk("t5_start", FW'(start),     FW'(1'b0));
    chk("t5_ready", FW'(pix_ready), FW'(1'b0));
    rst = 1'b0;
    #1;
    chk("t5_ready1", FW'(pix_ready), FW'(1'b1));
    for (int j = 0; j < LEDS; j++) push(24'($urandom), 1'b0);
    expect_commit("t5b");

    // Brightness scaling of a single pixel (identity when the feature is off)
    pulse_done();
    brightness = 8'd127;
    push(24'hFF8001, 1'b1);
    expect_commit("br127");
    px = led_rgb[23:0];
`ifdef LED_FRAME_BRIGHTNESS_EN
    chk("br127_px", FW'(px), FW'(24'h7F4000));
`else
    chk("br127_px", FW'(px), FW'(24'hFF8001));
`endif
    pulse_done();
    brightness = 8'd255;
    push(24'hFF8001, 1'b1);
    expect_commit("br255");
    px = led_rgb[23:0];
    chk("br255_px", FW'(px), FW'(24'hFF8001));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/led_frame_buffer.md
# led_frame_buffer

Double-buffered pixel collector that sits directly upstream of `LEDDriver`. It accepts one 24-bit RGB pixel per handshake and assembles a complete frame of `LEDS` pixels. It then commits the frame to the packed `led_rgb` vector and pulses `start`. While the driver shifts the committed frame out, the next frame is filled. It replaces the fixed-pattern source with a streamed source.

## Interface
- `LEDS`, 50, number of WS2801 LEDs per frame; minimum 2.
- `clk`  in  1  system clock (same clock as `LEDDriver`).
- `rst`  in  1  reset; synchronous and active-high.
- `pix_valid`  in  1  upstream pixel valid.
- `pix_ready`  out  1  block can accept a pixel.
- `pix_rgb`  in  24  pixel, `{R[23:16], G[15:8], B[7:0]}`.
- `pix_last`  in  1  marks the final pixel of a frame; qualified by the accept.
- `brightness`  in  8  global brightness; used only with `LED_FRAME_BRIGHTNESS_EN`.
- `led_rgb`  out  24*LEDS  committed frame. LED i occupies `[24*i +: 24]`. LED 0 is nearest the controller.
- `start`  out  1  one-cycle pulse to `LEDDriver`.
- `done`  in  1  driver completion. Any cycle with `done` high while busy ends the transfer.
- `frame_err`  out  1  one-cycle pulse when a frame is short.

## Operation
- Storage:
  - Write buffer `wbuf` is 24*LEDS bits.
  - Display buffer drives `led_rgb` directly.
  - `wr_idx` counts 0..LEDS-1, width `$clog2(LEDS)`.
  - `busy` flag covers the driver transfer.
- States:
  - FILL:
    - `pix_ready`=1.
    - On accept (`pix_valid & pix_ready`), write the pixel to `wbuf[24*wr_idx +: 24]`.
    - If `wr_idx==LEDS-1` or `pix_last`, go to FULL and clear `wr_idx` to 0.
    - Otherwise increment `wr_idx`.
  - FULL:
    - `pix_ready`=0.
    - When `busy`=0: copy `wbuf` to `led_rgb`, set `start`=1 for one cycle, set `busy`=1, return to FILL.
- `busy` clears on any cycle where `done`=1 while `busy`=1. `done` while not busy is ignored.
- Short frame:
  - `pix_last` accepted at `wr_idx<LEDS-1` pulses `frame_err` for one cycle and commits the frame anyway.
  - Unwritten slots keep their stale `wbuf` contents.
- Full frame without `pix_last`:
  - The frame commits at index LEDS-1 with no error.
  - The next accepted pixel starts a new frame at index 0.
- `wbuf` is not cleared between frames.

## Timing
- Reset values:
  - `led_rgb`=0, `wbuf`=0, `start`=0, `frame_err`=0.
  - `busy`=0, `wr_idx`=0, state FILL.
  - `pix_ready`=0 while `rst`=1, and 1 in the first cycle after `rst` deasserts.
- Last pixel accepted at edge N:
  - `pix_ready`=0 and state FULL after edge N.
  - If not busy, `led_rgb` updates and `start`=1 after edge N+1.
  - `pix_ready`=1 again after edge N+1.
- `frame_err` is registered. It is high in the cycle after the accepting edge, coincident with state FULL.
- `done` high in cycle k clears `busy` at edge k. A pending FULL frame commits at edge k+1 at the earliest.
- `start` is never high in two consecutive cycles. `led_rgb` never changes while `busy`=1.
- Reset mid-transfer clears `busy`, `start` and state immediately. `led_rgb` returns to 0.
- Throughput: one pixel per cycle in FILL, with one bubble cycle per frame (FULL).

## Configuration
- `LED_FRAME_BRIGHTNESS_EN` defined:
  - On accept, each 8-bit channel c is stored as `(c*(brightness+1))>>8`.
  - Multiply is 8x9 bits; the result is truncated to 8 bits.
  - `brightness`=255 is identity; `brightness`=0 stores 0.
  - Latency is unchanged; the scaling is combinational at the write.
- Undefined:
  - `pix_rgb` is stored verbatim.
  - The `brightness` port is present and ignored.

## Test plan
- LEDS=4, reset then stream `0x010203`, `0x040506`, `0x070809`, `0x0A0B0C`, one per cycle → exactly one `start` pulse two cycles after the 4th accept. `led_rgb` = `0x0A0B0C_070809_040506_010203`. `frame_err` stays 0.
- Second frame streamed while `busy` (no `done`) → `pix_ready` drops after 4 accepts and `led_rgb` is unchanged. `done` pulse in cycle k → new frame in `led_rgb` and `start` pulse after edge k+1.
- LEDS=4, two pixels with `pix_last` on the second → `frame_err` pulse for 1 cycle. LEDs 2–3 keep previous `wbuf` values; `start` fires.
- `pix_valid` toggling 1-0-1-0 → only accepted pixels land, at consecutive indices, with no gaps in `led_rgb`.
- `rst` asserted one cycle after `start` → `busy`=0, `led_rgb`=0, `wr_idx`=0. A fresh 4-pixel frame then starts normally without waiting for `done`.
- With `LED_FRAME_BRIGHTNESS_EN`, `brightness`=127 and pixel `0xFF8001` → stored `0x7F4000`. With `brightness`=255 → stored `0xFF8001`.
